// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the RV32I MEM stage.
//
// Holds a DEPTH x 32-bit word RAM and services one load or store at a time.
// A request accepted in IDLE is answered LATENCY cycles later with a
// one-cycle resp_valid_o pulse. Loads apply RV32I byte/half/word lane
// selection with sign or zero extension. Stores merge the selected lanes into
// the addressed word on the clock edge that ends the response cycle.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses do not write, return zero data
//               and raise resp_err_o with resp_valid_o.
//   undefined : resp_err_o is tied low; misaligned low address bits are
//               forced down (half ignores addr[0], word ignores addr[1:0]).
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   req_valid_i    MEM stage presents a load or store
//   req_ready_o    responder can accept a request this cycle (IDLE)
//   req_write_i    1 = store, 0 = load
//   req_funct3_i   RV32I funct3 of the access
//   req_addr_i     byte address; only addr[AW+1:0] is used (wraps mod DEPTH)
//   req_wdata_i    store data
//   resp_valid_o   one-cycle completion pulse
//   resp_rdata_o   extended load data, zero unless resp_valid_o on a load
//   resp_err_o     misaligned-access flag, meaningful with resp_valid_o
//   stall_mem_o    hold MEM and earlier stages

module dmem_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        stall_mem_o
);

    localparam int unsigned AW   = $clog2(DEPTH);
    // Counter only needs to hold LATENCY-1; keep at least one bit.
    localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              write_q;
    logic [2:0]        funct3_q;
    logic [AW+1:0]     addr_q;
    logic [31:0]       wdata_q;

    logic [31:0]       mem_q [DEPTH];

    logic              accept;
    logic [AW-1:0]     widx;
    logic [31:0]       mem_word;

    logic              acc_byte;
    logic              acc_half;
    logic              acc_word;
    logic              access_ok;
    logic              misalign_err;
    logic [1:0]        lane_off;
    logic [31:0]       lane_shifted;
    logic [31:0]       load_data;
    logic [3:0]        byte_en;
    logic [31:0]       wdata_rep;
    logic [31:0]       merged_word;

    // Address bits above the RAM index are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr_i[31:AW+2];

    assign accept = (state_q == StIdle) && req_valid_i;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    if (LATENCY == 1) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntLoad;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 1'b1;
                // Counter hits zero on this edge, so the next cycle is RESP.
                if (cnt_q <= CntW'(1)) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                write_q  <= req_write_i;
                funct3_q <= req_funct3_i;
                addr_q   <= req_addr_i[AW+1:0];
                wdata_q  <= req_wdata_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    assign widx     = addr_q[AW+1:2];
    assign mem_word = mem_q[widx];

    // Width of a legal access; illegal funct3 codes leave all three low.
    always_comb begin
        acc_byte = 1'b0;
        acc_half = 1'b0;
        acc_word = 1'b0;
        if (write_q) begin
            case (funct3_q)
                3'b000:  acc_byte = 1'b1;
                3'b001:  acc_half = 1'b1;
                3'b010:  acc_word = 1'b1;
                default: ;
            endcase
        end else begin
            case (funct3_q)
                3'b000, 3'b100: acc_byte = 1'b1;
                3'b001, 3'b101: acc_half = 1'b1;
                3'b010:         acc_word = 1'b1;
                default:        ;
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign misalign_err = (acc_half && addr_q[0]) ||
                          (acc_word && (addr_q[1:0] != 2'b00));
    assign access_ok    = ~misalign_err;
    assign lane_off     = addr_q[1:0];
`else
    assign misalign_err = 1'b0;
    assign access_ok    = 1'b1;
    // Force misaligned low bits down to the natural alignment.
    assign lane_off     = acc_word ? 2'b00 :
                          acc_half ? {addr_q[1], 1'b0} :
                                     addr_q[1:0];
`endif

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
    assign lane_shifted = mem_word >> {lane_off, 3'b000};

    always_comb begin
        load_data = 32'h0;
        if (!write_q && access_ok) begin
            case (funct3_q)
                3'b000:  load_data = {{24{lane_shifted[7]}}, lane_shifted[7:0]};
                3'b001:  load_data = {{16{lane_shifted[15]}}, lane_shifted[15:0]};
                3'b010:  load_data = mem_word;
                3'b100:  load_data = {24'h0, lane_shifted[7:0]};
                3'b101:  load_data = {16'h0, lane_shifted[15:0]};
                default: load_data = 32'h0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Store path: merge selected lanes into the current word
    // ------------------------------------------------------------------
    always_comb begin
        byte_en   = 4'b0000;
        wdata_rep = wdata_q;
        if (write_q && access_ok) begin
            if (acc_byte) begin
                byte_en   = 4'b0001 << lane_off;
                wdata_rep = {4{wdata_q[7:0]}};
            end else if (acc_half) begin
                byte_en   = lane_off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_q[15:0]}};
            end else if (acc_word) begin
                byte_en   = 4'b1111;
                wdata_rep = wdata_q;
            end
        end
    end

    always_comb begin
        merged_word = mem_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                merged_word[8*i +: 8] = wdata_rep[8*i +: 8];
            end
        end
    end

    // RAM contents are not reset; reset only blocks a pending commit.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == StResp) && (byte_en != 4'b0000)) begin
            mem_q[widx] <= merged_word;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready_o  = (state_q == StIdle);
    assign resp_valid_o = (state_q == StResp);
    assign resp_rdata_o = resp_valid_o ? load_data : 32'h0;
    assign resp_err_o   = resp_valid_o & misalign_err;
    // Low in RESP so the pipeline advances and captures the data.
    assign stall_mem_o  = accept || (state_q == StWait);

endmodule
